prio_encoder8x3: RTL and testbench
==================================

# prio_encoder8x3

Registered 8-to-3 priority encoder with enable and valid flag. It reports the index of the highest-numbered asserted input bit, one clock after sampling. It serves as a request-arbitration and index-generation leaf block, and its per-bit output slices are reusable for cascading.

## Interface
Parameters:
- None. The width is fixed at 8 inputs and 3 outputs.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  encode enable, sampled each rising edge
- `x`  in  8  request vector; bit 7 has highest priority, bit 0 lowest
- `y`  out  3  binary index of the highest set bit of `x`; `y[2]` is the MSB
- `valid`  out  1  high when the registered `y` reflects a set request bit
- `eo`  out  1  enable-out for cascading; present only with `PRIO_ENC_EO_EN`

## Operation
- Combinational next-state:
  - `hit = en & |x`
  - `idx` = position of the highest 1 in `x`; 0 when `x` is 0
- Individual index bits:
  - `idx[2] = x7|x6|x5|x4`
  - `idx[1] = x7|x6|(~x5&~x4&(x3|x2))`
  - `idx[0] = x7|(~x6&x5)|(~x6&~x4&x3)|(~x6&~x4&~x2&x1)`
- Register update on each rising edge when not in reset:
  - `y <= hit ? idx : 3'd0`
  - `valid <= hit`
- Disabled (`en=0`): `y` is 0 and `valid` is 0, regardless of `x`.
- Enabled with `x=0`: `y` is 0 and `valid` is 0. Only `valid` distinguishes this from "bit 0 set" (`y=0`, `valid=1`).
- Lower-priority bits are don't-care once a higher bit is set.
- X/Z on `x` is not defined. The bench drives only 0/1.

## Timing
- Latency is 1 cycle: `x` and `en` sampled at edge N appear on `y`/`valid` after edge N.
- Throughput is one encode per cycle. There is no handshake and no backpressure.
- Reset values: `y=0`, `valid=0`, `eo=0`.
- Reset has priority over `en`. Asserting `rst` mid-stream clears all outputs at the next edge, and the sampled `x` is discarded.
- After `rst` deasserts, the first valid result appears one edge after the first enabled sample.
- `en` toggling every cycle is legal. Each cycle is encoded independently, and no state is kept other than the output registers.

## Configuration
- `PRIO_ENC_EO_EN` defined:
  - Adds port `eo`, registered as `eo <= en & ~|x` (reset 0).
  - A higher-priority stage's `eo` drives a lower stage's `en` for 16/24-input cascades.
- `PRIO_ENC_EO_EN` undefined:
  - The `eo` port and its register do not exist.
  - All other behaviour is identical.

## Structure
- Shared package `prio_enc_pkg`:
  - `PRIO_IN_W = 8`, `PRIO_OUT_W = 3`
  - typedefs `prio_req_t` (logic [7:0]) and `prio_idx_t` (logic [2:0])
- One combinational sub-module `prio_enc_bit`:
  - Parameter `BIT` (0..2) selects which index-bit equation it implements.
  - Ports: `y_bit`, `en`, `x[7:0]`.
  - The top instantiates three slices and registers their outputs together with `valid`/`eo`.

## Test plan
- Reset and disable:
  - Hold `rst=1` for 2 cycles with `x=8'hA5`, `en=1` -> `y=0`, `valid=0`, `eo=0`.
  - Release reset with `en=0` and random `x` -> outputs stay 0.
- Priority sweep with `en=1` (each result is checked one cycle after the input is applied):
  - `10100100` -> y=7
  - `01101000` -> y=6
  - `00100110` -> y=5
  - `00010101` -> y=4
  - `00001111` -> y=3
  - `00000101` -> y=2
  - `00000010` -> y=1
  - `00000001` -> y=0
  - `valid=1` for every entry.
- Zero input:
  - `x=00000000`, `en=1` -> `y=0`, `valid=0`; `eo=1` when the macro is defined.
- Masked lower bits:
  - `01001000` -> y=6
  - `01000000` -> y=6
  - `01111011` -> y=6
- Mid-stream reset:
  - Stream `x=8'h80`, `en=1`, and assert `rst` for one cycle -> that cycle's output is 0/0, and the next cycle returns y=7, `valid=1`.
- Exhaustive:
  - All 256 values of `x` with both values of `en`, compared against a reference model of the highest-set-bit index.

Source files
------------

// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_pkg
//  Description : Shared widths and types for the 8-to-3 priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    localparam int PRIO_IN_W  = 8;
    localparam int PRIO_OUT_W = 3;

    typedef logic [PRIO_IN_W-1:0]  prio_req_t;
    typedef logic [PRIO_OUT_W-1:0] prio_idx_t;

endpackage : prio_enc_pkg
`default_nettype wire

// File: rtl/prio_enc_bit.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_bit
//  Description : One combinational output-bit slice of the 8-to-3 priority
//                encoder. BIT (0..2) selects which index bit is produced.
//                The slice is gated by en so a disabled encoder yields 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_bit
    import prio_enc_pkg::*;
#(
    parameter int BIT = 0
) (
    output logic      y_bit,
    input  logic      en,
    input  prio_req_t x
);

    logic w_eq;
    // Not every slice reads every request bit; fold the vector so the port
    // is fully consumed without affecting the result.
    logic w_unused_x;
    assign w_unused_x = ^x;

    generate
        if (BIT == 2) begin : g_bit2
            // Any request in the upper nibble sets the MSB of the index.
            assign w_eq = x[7] | x[6] | x[5] | x[4];
        end else if (BIT == 1) begin : g_bit1
            // Indices 7,6 or, with the upper pair of the nibble clear, 3,2.
            assign w_eq = x[7] | x[6] | (~x[5] & ~x[4] & (x[3] | x[2]));
        end else begin : g_bit0
            // Odd indices, each qualified by all higher even bits being clear.
            assign w_eq = x[7]
                        | (~x[6] & x[5])
                        | (~x[6] & ~x[4] & x[3])
                        | (~x[6] & ~x[4] & ~x[2] & x[1]);
        end
    endgenerate

    // Zero the slice when the encoder is disabled.
    assign y_bit = en & w_eq;

endmodule : prio_enc_bit
`default_nettype wire

// File: rtl/prio_encoder8x3.sv
`default_nettype none
// ============================================================================
//  Module      : prio_encoder8x3
//  Description : Registered 8-to-3 priority encoder with enable and valid.
//                y reports the index of the highest set bit of x one clock
//                after sampling; valid flags that a request was present.
//                Optional macro PRIO_ENC_EO_EN adds the cascading enable-out
//                port eo (registered en & no-request).
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder8x3
    import prio_enc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  prio_req_t x,
    output prio_idx_t y,
`ifdef PRIO_ENC_EO_EN
    output logic      eo,
`endif
    output logic      valid
);

    prio_idx_t w_idx;
    logic      w_hit;
    prio_idx_t r_y;
    logic      r_valid;

    // One combinational slice per index bit; each is already gated by en.
    generate
        for (genvar i = 0; i < PRIO_OUT_W; i++) begin : g_slice
            prio_enc_bit #(
                .BIT (i)
            ) u_bit (
                .y_bit (w_idx[i]),
                .en    (en),
                .x     (x)
            );
        end
    endgenerate

    // A request is reported only when enabled and at least one bit is set.
    assign w_hit = en & (|x);

    // Output registers; reset wins over any sampled request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_hit ? w_idx : '0;
            r_valid <= w_hit;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

`ifdef PRIO_ENC_EO_EN
    logic r_eo;

    // Enable-out: this stage was enabled but saw no request, so a lower
    // priority stage may take its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eo <= 1'b0;
        end else begin
            r_eo <= en & ~(|x);
        end
    end

    assign eo = r_eo;
`endif

endmodule : prio_encoder8x3
`default_nettype wire

// File: tb/tb_prio_encoder8x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_encoder8x3
//  Description : Self-checking bench for prio_encoder8x3. Vector table,
//                hand sequences for reset, exhaustive and random sweeps,
//                all checked against a highest-set-bit reference model.
//                Build with PRIO_ENC_EO_EN to also check eo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder8x3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] x;
    logic [2:0] y;
    logic       valid;
    logic       eo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder8x3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x     (x),
        .y     (y),
`ifdef PRIO_ENC_EO_EN
        .eo    (eo),
`endif
        .valid (valid)
    );

`ifndef PRIO_ENC_EO_EN
    assign eo = 1'b0;
`endif

    typedef struct {
        logic [7:0] x;
        logic       en;
        logic [2:0] y;
        logic       valid;
        logic       eo;
    } vec_t;

    // Reference: scan from the top bit down and return the first set index.
    function automatic int ref_idx(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Compare all outputs against explicit expectations.
    task automatic chk_out(input string name, input logic [2:0] ey, input logic ev, input logic eeo);
        chk({name, ".y"}, {5'd0, y}, {5'd0, ey});
        chk({name, ".valid"}, {7'd0, valid}, {7'd0, ev});
`ifdef PRIO_ENC_EO_EN
        chk({name, ".eo"}, {7'd0, eo}, {7'd0, eeo});
`else
        if (eeo === 1'bx) $display("unreachable");
`endif
    endtask

    // Apply one sample, let it be clocked in, then check against the model.
    task automatic run(input string name, input logic [7:0] xv, input logic env, input logic rstv);
        logic [2:0] ey;
        logic       ev;
        logic       eeo;
        x   = xv;
        en  = env;
        rst = rstv;
        @(posedge clk);
        #1;
        ev  = !rstv && env && (xv != 8'd0);
        ey  = ev ? 3'(ref_idx(xv)) : 3'd0;
        eeo = !rstv && env && (xv == 8'd0);
        chk_out(name, ey, ev, eeo);
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{8'b10100100, 1'b1, 3'd7, 1'b1, 1'b0};
        tbl[1]  = '{8'b01101000, 1'b1, 3'd6, 1'b1, 1'b0};
        tbl[2]  = '{8'b00100110, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[3]  = '{8'b00010101, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{8'b00001111, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{8'b00000101, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[6]  = '{8'b00000010, 1'b1, 3'd1, 1'b1, 1'b0};
        tbl[7]  = '{8'b00000001, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{8'b00000000, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[9]  = '{8'b01001000, 1'b1, 3'd6, 1'b1, 1'b0};
        tbl[10] = '{8'b01000000, 1'b1, 3'd6, 1'b1, 1'b0};
        tbl[11] = '{8'b01111011, 1'b1, 3'd6, 1'b1, 1'b0};

        // Reset held two cycles with an active request present.
        rst = 1'b1;
        en  = 1'b1;
        x   = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 3'd0, 1'b0, 1'b0);

        // Released but disabled: outputs stay clear whatever x is.
        for (int i = 0; i < 4; i++) begin
            run("disabled", 8'($urandom), 1'b0, 1'b0);
        end

        // Priority sweep, zero input and masked-lower-bit table.
        for (int i = 0; i < 12; i++) begin
            x   = tbl[i].x;
            en  = tbl[i].en;
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk_out($sformatf("tbl%0d", i), tbl[i].y, tbl[i].valid, tbl[i].eo);
        end

        // Mid-stream reset: one cleared cycle, then normal encoding resumes.
        run("stream_pre", 8'h80, 1'b1, 1'b0);
        x = 8'h80; en = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("mid_rst", 3'd0, 1'b0, 1'b0);
        x = 8'h80; en = 1'b1; rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_rst", 3'd7, 1'b1, 1'b0);

        // en toggling every cycle on a constant request.
        for (int i = 0; i < 6; i++) begin
            run("toggle", 8'h24, 1'(i % 2), 1'b0);
        end

        // Exhaustive over x and en.
        for (int e = 0; e < 2; e++) begin
            for (int v = 0; v < 256; v++) begin
                run($sformatf("exh_en%0d_x%02h", e, v), 8'(v), 1'(e), 1'b0);
            end
        end

        // Random stream with occasional resets.
        for (int i = 0; i < 300; i++) begin
            run("rand", 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prio_encoder8x3
`default_nettype wire
